// File: rtl/sde_trigger_arbiter_pkg.sv
// sde_trigger_arbiter_pkg
//   Shared definitions for the trigger arbiter: FSM state encodings (3-bit),
//   the MISSED counter width and the widths of the configuration fields
//   (COINC_WIN, DEAD_TIME, PRESCALE).
package sde_trigger_arbiter_pkg;

   typedef enum logic [2:0] {
      SDE_ARB_ST_IDLE     = 3'd0,
      SDE_ARB_ST_COLLECT  = 3'd1,
      SDE_ARB_ST_ISSUE    = 3'd2,
      SDE_ARB_ST_WAIT_ACK = 3'd3,
      SDE_ARB_ST_DEAD     = 3'd4
   } sde_arb_state_e;

   localparam int unsigned SDE_ARB_MISSED_WIDTH = 16;

   localparam int unsigned SDE_ARB_COINC_WIN_WIDTH = 4;
   localparam int unsigned SDE_ARB_DEAD_TIME_WIDTH = 16;
   localparam int unsigned SDE_ARB_PRESCALE_WIDTH  = 8;

endpackage

// File: rtl/sde_arb_downcounter.sv
// sde_arb_downcounter
//   Loadable down-counter with a terminal-count flag. Stops at zero.
//   CLK120   : clock (rising edge)
//   RESET    : synchronous active-high reset, clears the count
//   load     : load load_val (takes priority over dec)
//   load_val : value to load
//   dec      : decrement by one when the count is non-zero
//   tc       : high while the count equals TC_VALUE
module sde_arb_downcounter #(
   parameter int unsigned WIDTH    = 4,
   parameter int unsigned TC_VALUE = 0
) (
   input  logic             CLK120,
   input  logic             RESET,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             dec,
   output logic             tc
);

   logic [WIDTH-1:0] count_q;

   always_ff @(posedge CLK120) begin
      if (RESET) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= load_val;
      end else if (dec && (count_q != '0)) begin
         count_q <= count_q - 1'b1;
      end
   end

   assign tc = (count_q == WIDTH'(TC_VALUE));

endmodule

// File: rtl/sde_trigger_arbiter.sv
// sde_trigger_arbiter
//   Merges one-cycle trigger pulses into a single event trigger: collects
//   coincident sources over COINC_WIN+1 cycles, issues the event with a
//   valid/ack handshake, then holds off for DEAD_TIME cycles. Triggers that
//   arrive while the block cannot take them are counted in MISSED.
//   Optional build macro SDE_TRIG_ARB_PRESCALE_EN adds PRESCALE [7:0]: only
//   every (PRESCALE+1)th acceptable trigger starts an event.
// Ports:
//   CLK120, RESET           : clock, synchronous active-high reset
//   TRIG_IN, SRC_ENAB       : trigger pulses and per-source enables
//   COINC_WIN, DEAD_TIME    : window extension / dead-time length in cycles
//   BUF_FULL, EVT_ACK       : buffer back-pressure and event capture ack
//   EVT_TRIG, EVT_VALID     : event strobe and held-valid
//   EVT_SRC, EVT_ID         : sources in the event and event number
//   MISSED, BUSY            : saturating drop count, not-idle flag
module sde_trigger_arbiter
   import sde_trigger_arbiter_pkg::*;
#(
   parameter int unsigned N_SRC      = 4,
   parameter int unsigned WIN_WIDTH  = SDE_ARB_COINC_WIN_WIDTH,
   parameter int unsigned DEAD_WIDTH = SDE_ARB_DEAD_TIME_WIDTH,
   parameter int unsigned ID_WIDTH   = 16
) (
   input  logic                            CLK120,
   input  logic                            RESET,
   input  logic [N_SRC-1:0]                TRIG_IN,
   input  logic [N_SRC-1:0]                SRC_ENAB,
   input  logic [WIN_WIDTH-1:0]            COINC_WIN,
   input  logic [DEAD_WIDTH-1:0]           DEAD_TIME,
   input  logic                            BUF_FULL,
   input  logic                            EVT_ACK,
`ifdef SDE_TRIG_ARB_PRESCALE_EN
   input  logic [SDE_ARB_PRESCALE_WIDTH-1:0] PRESCALE,
`endif
   output logic                            EVT_TRIG,
   output logic                            EVT_VALID,
   output logic [N_SRC-1:0]                EVT_SRC,
   output logic [ID_WIDTH-1:0]             EVT_ID,
   output logic [SDE_ARB_MISSED_WIDTH-1:0] MISSED,
   output logic                            BUSY
);

   sde_arb_state_e state_q, state_d;

   logic [N_SRC-1:0]                q_q;
   logic [N_SRC-1:0]                acc_q, acc_d;
   logic                            evt_trig_q, evt_trig_d;
   logic                            evt_valid_q, evt_valid_d;
   logic [N_SRC-1:0]                evt_src_q, evt_src_d;
   logic [ID_WIDTH-1:0]             evt_id_q, evt_id_d;
   logic [SDE_ARB_MISSED_WIDTH-1:0] missed_q, missed_d;
   logic                            busy_q;

   logic q_nz;
   logic drop;
   logic presc_hit;
   logic win_load, win_dec, win_tc;
   logic dead_load, dead_dec, dead_tc;

   assign q_nz = |q_q;

`ifdef SDE_TRIG_ARB_PRESCALE_EN
   logic [SDE_ARB_PRESCALE_WIDTH-1:0] presc_q, presc_d;
   logic                              presc_take;

   // Counts acceptable triggers seen in IDLE; only the one that matches
   // PRESCALE starts an event.
   assign presc_hit  = (presc_q == PRESCALE);
   assign presc_take = (state_q == SDE_ARB_ST_IDLE) && q_nz && !BUF_FULL;

   always_comb begin
      presc_d = presc_q;
      if (presc_take) begin
         presc_d = presc_hit ? '0 : presc_q + 1'b1;
      end
   end

   always_ff @(posedge CLK120) begin
      if (RESET) begin
         presc_q <= '0;
      end else begin
         presc_q <= presc_d;
      end
   end
`else
   assign presc_hit = 1'b1;
`endif

   sde_arb_downcounter #(
      .WIDTH    (WIN_WIDTH),
      .TC_VALUE (0)
   ) u_win_cnt (
      .CLK120   (CLK120),
      .RESET    (RESET),
      .load     (win_load),
      .load_val (COINC_WIN),
      .dec      (win_dec),
      .tc       (win_tc)
   );

   // Terminal count at 1 so the dead period is exactly DEAD_TIME cycles.
   sde_arb_downcounter #(
      .WIDTH    (DEAD_WIDTH),
      .TC_VALUE (1)
   ) u_dead_cnt (
      .CLK120   (CLK120),
      .RESET    (RESET),
      .load     (dead_load),
      .load_val (DEAD_TIME),
      .dec      (dead_dec),
      .tc       (dead_tc)
   );

   assign win_dec  = (state_q == SDE_ARB_ST_COLLECT) && !win_tc;
   assign dead_dec = (state_q == SDE_ARB_ST_DEAD);

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      evt_trig_d  = 1'b0;
      evt_valid_d = evt_valid_q;
      evt_src_d   = evt_src_q;
      evt_id_d    = evt_id_q;
      drop        = 1'b0;
      win_load    = 1'b0;
      dead_load   = 1'b0;

      case (state_q)
         SDE_ARB_ST_IDLE: begin
            if (q_nz) begin
               if (BUF_FULL) begin
                  drop = 1'b1;
               end else if (presc_hit) begin
                  acc_d    = q_q;
                  win_load = 1'b1;
                  state_d  = SDE_ARB_ST_COLLECT;
               end
            end
         end
         SDE_ARB_ST_COLLECT: begin
            acc_d = acc_q | q_q;
            if (win_tc) begin
               state_d = SDE_ARB_ST_ISSUE;
            end
         end
         SDE_ARB_ST_ISSUE: begin
            drop        = q_nz;
            evt_trig_d  = 1'b1;
            evt_valid_d = 1'b1;
            evt_src_d   = acc_q;
            state_d     = SDE_ARB_ST_WAIT_ACK;
         end
         SDE_ARB_ST_WAIT_ACK: begin
            drop = q_nz;
            if (EVT_ACK) begin
               evt_valid_d = 1'b0;
               evt_id_d    = evt_id_q + 1'b1;
               if (DEAD_TIME == '0) begin
                  state_d = SDE_ARB_ST_IDLE;
               end else begin
                  dead_load = 1'b1;
                  state_d   = SDE_ARB_ST_DEAD;
               end
            end
         end
         SDE_ARB_ST_DEAD: begin
            drop = q_nz;
            if (dead_tc) begin
               state_d = SDE_ARB_ST_IDLE;
            end
         end
         default: begin
            state_d = SDE_ARB_ST_IDLE;
         end
      endcase
   end

   assign missed_d = (drop && (missed_q != '1)) ? missed_q + 1'b1 : missed_q;

   always_ff @(posedge CLK120) begin
      if (RESET) begin
         state_q     <= SDE_ARB_ST_IDLE;
         q_q         <= '0;
         acc_q       <= '0;
         evt_trig_q  <= 1'b0;
         evt_valid_q <= 1'b0;
         evt_src_q   <= '0;
         evt_id_q    <= '0;
         missed_q    <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         q_q         <= TRIG_IN & SRC_ENAB;
         acc_q       <= acc_d;
         evt_trig_q  <= evt_trig_d;
         evt_valid_q <= evt_valid_d;
         evt_src_q   <= evt_src_d;
         evt_id_q    <= evt_id_d;
         missed_q    <= missed_d;
         busy_q      <= (state_q != SDE_ARB_ST_IDLE);
      end
   end

   assign EVT_TRIG  = evt_trig_q;
   assign EVT_VALID = evt_valid_q;
   assign EVT_SRC   = evt_src_q;
   assign EVT_ID    = evt_id_q;
   assign MISSED    = missed_q;
   assign BUSY      = busy_q;

endmodule

// File: doc/sde_trigger_arbiter.md
# sde_trigger_arbiter

Merges the one-cycle trigger pulses from the station's trigger modules into a single event trigger for the event-buffer controller. The trigger modules include the single-bin, ToT and external triggers. The block runs in the CLK120 domain, downstream of all trigger generators. It collects coincident sources over a programmable window and hands the event off with a valid/ack handshake. It then enforces a programmable dead time and counts the triggers it drops.

## Interface
Parameters:
- N_SRC, 4, number of trigger sources; bit 0 = single-bin trigger
- WIN_WIDTH, 4, width of coincidence-window count
- DEAD_WIDTH, 16, width of dead-time count
- ID_WIDTH, 16, width of event counter

Ports:
- CLK120  in  1  the block's only clock; all logic on its rising edge
- RESET  in  1  synchronous, active-high reset
- TRIG_IN  in  N_SRC  one-cycle trigger pulses from the trigger modules
- SRC_ENAB  in  N_SRC  per-source enable
- COINC_WIN  in  WIN_WIDTH  extra collection cycles after the first trigger
- DEAD_TIME  in  DEAD_WIDTH  dead cycles after each ack
- BUF_FULL  in  1  event buffer cannot accept a new event
- EVT_ACK  in  1  buffer controller has captured EVT_SRC/EVT_ID
- EVT_TRIG  out  1  single-cycle event strobe
- EVT_VALID  out  1  EVT_SRC/EVT_ID valid, held until ack
- EVT_SRC  out  N_SRC  OR of all sources seen in the window
- EVT_ID  out  ID_WIDTH  event number of the current event
- MISSED  out  16  saturating count of dropped triggers
- BUSY  out  1  high whenever the state is not IDLE

## Operation
- Input stage: Q <= TRIG_IN & SRC_ENAB, registered.
- The FSM has five states: IDLE, COLLECT, ISSUE, WAIT_ACK and DEAD.
- IDLE, Q!=0 and !BUF_FULL: set ACC<=Q, WCNT<=COINC_WIN, go to COLLECT.
- IDLE, Q!=0 and BUF_FULL: the trigger is dropped (counted in MISSED).
- COLLECT: ACC|=Q every cycle including the last one.
  - If WCNT==0, go to ISSUE; else WCNT-=1.
  - COLLECT therefore lasts COINC_WIN+1 cycles.
  - BUF_FULL rising during COLLECT does not abort the event.
- ISSUE (one cycle): register EVT_TRIG<=1, EVT_VALID<=1, EVT_SRC<=ACC; go to WAIT_ACK.
- WAIT_ACK: EVT_VALID, EVT_SRC and EVT_ID are held stable. On EVT_ACK:
  - EVT_VALID<=0.
  - EVT_ID+=1, wrapping at 2^ID_WIDTH.
  - If DEAD_TIME==0, go to IDLE; else DCNT<=DEAD_TIME and go to DEAD.
- DEAD: DCNT-=1; when DCNT==1, go to IDLE. The dead period is exactly DEAD_TIME cycles.
- EVT_ACK is sampled only in WAIT_ACK; it is ignored in every other state.
- Drop rule: any cycle with Q!=0 in ISSUE, WAIT_ACK or DEAD, or in IDLE with BUF_FULL, adds 1 to MISSED.
  - MISSED saturates at 16'hFFFF.
  - Several sources in one cycle count as 1.
- Configuration inputs are sampled when used: COINC_WIN on entry to COLLECT, DEAD_TIME at ack.

## Timing
- Reset values: EVT_TRIG=0, EVT_VALID=0, EVT_SRC=0, EVT_ID=0, MISSED=0, BUSY=0, state=IDLE. WCNT, DCNT and ACC are also cleared.
- RESET mid-event aborts immediately: no strobe is issued and no ID increment occurs.
- Latency: TRIG_IN high at cycle 0 gives EVT_TRIG high at cycle 4+COINC_WIN, and EVT_VALID rises in that same cycle.
- EVT_TRIG is high exactly 1 cycle per event.
- Earliest ack: EVT_ACK in the cycle EVT_VALID rises is accepted, and EVT_VALID falls in the next cycle.
- With DEAD_TIME=0, a new trigger is accepted from the cycle after EVT_VALID falls.
- BUSY is registered and follows the state with a 1-cycle lag.

## Configuration
- SDE_TRIG_ARB_PRESCALE_EN defined:
  - Adds input PRESCALE [7:0] and an 8-bit prescale counter.
  - In IDLE, only every (PRESCALE+1)th acceptable trigger starts COLLECT. The counter is reset to 0 on each acceptance and by RESET.
  - Prescaled-away triggers are not counted in MISSED.
  - PRESCALE=0 accepts all triggers.
- SDE_TRIG_ARB_PRESCALE_EN undefined: no PRESCALE port and no counter; every acceptable trigger is taken.

## Structure
- sde_trigger_defs.vh gains:
  - SDE_ARB_ST_* state encodings (3-bit).
  - SDE_ARB_MISSED_WIDTH (16).
  - Register-field shift/width macros for the COINC_WIN, DEAD_TIME and PRESCALE fields.
- One sub-module: sde_arb_downcounter, a loadable down-counter with a terminal-count flag, instantiated twice (window and dead time).

## Test plan
- SRC_ENAB=4'hF, COINC_WIN=0, single TRIG_IN=4'b0001 at cycle 0 -> EVT_TRIG at cycle 4, EVT_SRC=4'b0001, EVT_ID=0; ack -> EVT_ID=1.
- COINC_WIN=3, pulses 0001 at cycle 0 and 0100 at cycle 3 -> one event at cycle 7 with EVT_SRC=4'b0101.
- DEAD_TIME=10, triggers every cycle for 30 cycles, ack 2 cycles after EVT_VALID -> exactly one event per dead period; MISSED equals the count of dropped cycles.
- BUF_FULL=1 with 5 triggers -> no EVT_TRIG, MISSED=5. Force MISSED to 16'hFFFE, then 3 more drops -> MISSED=16'hFFFF.
- RESET pulsed during WAIT_ACK -> EVT_VALID=0 next cycle, EVT_ID=0, BUSY=0; next trigger gives EVT_ID=0.
- With the macro, PRESCALE=2, 9 triggers spaced 20 cycles with prompt ack -> 3 events, MISSED=0.
